// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - shared types and constants for the writeback stage
package writeback_unit_pkg;

  // Writeback sequencing: idle, waiting on a load response, or presenting a write.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } wb_state_t;

  // Load access sizes; the unused encoding 2'b11 behaves as a word.
  localparam logic [1:0] LOAD_BYTE = 2'b00;
  localparam logic [1:0] LOAD_HALF = 2'b01;
  localparam logic [1:0] LOAD_WORD = 2'b10;

  localparam int WB_DATA_W = 32;
  localparam int WB_REG_AW = 5;

endpackage

// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - memory-stage input, memory response and register-file write bundle
interface writeback_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rd;
  logic              in_reg_write;
  logic              in_is_load;
  logic              in_is_link;
  logic [1:0]        in_load_size;
  logic              in_load_unsigned;
  logic [1:0]        in_addr_lo;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_pc_plus4;
  logic              mem_rdata_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              write_enable;
  logic [REG_AW-1:0] write_register;
  logic [DATA_W-1:0] write_data;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [DATA_W-1:0] fwd_data;
  logic              load_timeout;

  // Upstream side: memory stage, data memory and the register-file consumer.
  modport master (
    output in_valid, in_rd, in_reg_write, in_is_load, in_is_link,
    output in_load_size, in_load_unsigned, in_addr_lo, in_alu_result, in_pc_plus4,
    output mem_rdata_valid, mem_rdata,
    input  in_ready, write_enable, write_register, write_data,
    input  fwd_valid, fwd_rd, fwd_data, load_timeout
  );

  // The writeback unit itself.
  modport slave (
    input  in_valid, in_rd, in_reg_write, in_is_load, in_is_link,
    input  in_load_size, in_load_unsigned, in_addr_lo, in_alu_result, in_pc_plus4,
    input  mem_rdata_valid, mem_rdata,
    output in_ready, write_enable, write_register, write_data,
    output fwd_valid, fwd_rd, fwd_data, load_timeout
  );

endinterface

// File: rtl/writeback_unit_load_align.sv
// rtl/writeback_unit_load_align.sv - extracts and extends a byte/half/word from a raw memory word
module writeback_unit_load_align
  import writeback_unit_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  logic [1:0]        i_load_size,
  input  logic              i_load_unsigned,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_raw,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_byte_sign;
  logic        w_half_sign;

  // Select the addressed lane, then zero- or sign-extend it to the datapath width.
  always_comb begin
    w_byte      = i_raw[{i_addr_lo, 3'b000} +: 8];
    w_half      = i_raw[{i_addr_lo[1], 4'b0000} +: 16];
    w_byte_sign = w_byte[7] & ~i_load_unsigned;
    w_half_sign = w_half[15] & ~i_load_unsigned;
    o_data      = i_raw;
    case (i_load_size)
      LOAD_BYTE: o_data = {{(DATA_W-8){w_byte_sign}}, w_byte};
      LOAD_HALF: o_data = {{(DATA_W-16){w_half_sign}}, w_half};
      LOAD_WORD: o_data = i_raw;
      default:   o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - final pipeline stage driving the register-file write port and bypass
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DATA_W   = WB_DATA_W,
  parameter int REG_AW   = WB_REG_AW,
  parameter int LOAD_TMO = 15
) (
  input  logic          clock,
  input  logic          reset,
  writeback_unit_if.slave bus
);

  localparam int CNT_W = $clog2(LOAD_TMO + 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(LOAD_TMO);

  wb_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [REG_AW-1:0] r_rd;
  logic              r_reg_write;
  logic [1:0]        r_load_size;
  logic              r_load_unsigned;
  logic [1:0]        r_addr_lo;
  logic              r_we;
  logic [REG_AW-1:0] r_wreg;
  logic [DATA_W-1:0] r_wdata;
  logic              r_timeout;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_new_we;
  logic              w_load_we;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [DATA_W-1:0] w_aligned;

  // The unit can take a new instruction whenever it is not blocked on a load.
  assign w_in_ready = (r_state != S_WAIT_MEM);
  assign w_accept   = bus.in_valid & w_in_ready;
  // Writes to x0 still sequence through COMMIT but never strobe the register file.
  assign w_new_we   = bus.in_reg_write & (bus.in_rd != '0);
  assign w_load_we  = r_reg_write & (r_rd != '0);
  assign w_cnt_next = r_cnt + 1'b1;

  writeback_unit_load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .i_load_size     (r_load_size),
    .i_load_unsigned (r_load_unsigned),
    .i_addr_lo       (r_addr_lo),
    .i_raw           (bus.mem_rdata),
    .o_data          (w_aligned)
  );

  // FSM: latches accepted instructions, waits on load data, and registers the write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_rd            <= '0;
      r_reg_write     <= 1'b0;
      r_load_size     <= LOAD_BYTE;
      r_load_unsigned <= 1'b0;
      r_addr_lo       <= '0;
      r_we            <= 1'b0;
      r_wreg          <= '0;
      r_wdata         <= '0;
      r_timeout       <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_COMMIT: begin
          if (w_accept) begin
            r_rd            <= bus.in_rd;
            r_reg_write     <= bus.in_reg_write;
            r_load_size     <= bus.in_load_size;
            r_load_unsigned <= bus.in_load_unsigned;
            r_addr_lo       <= bus.in_addr_lo;
            if (bus.in_is_load) begin
              r_state <= S_WAIT_MEM;
              r_cnt   <= '0;
            end else begin
              r_state <= S_COMMIT;
              r_we    <= w_new_we;
              if (w_new_we) begin
                r_wreg  <= bus.in_rd;
                r_wdata <= bus.in_is_link ? bus.in_pc_plus4 : bus.in_alu_result;
              end
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT_MEM: begin
          if (bus.mem_rdata_valid) begin
            r_state <= S_COMMIT;
            r_we    <= w_load_we;
            if (w_load_we) begin
              r_wreg  <= r_rd;
              r_wdata <= w_aligned;
            end
          end else if (w_cnt_next == TMO_LIMIT) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.write_enable   = r_we;
  assign bus.write_register = r_wreg;
  assign bus.write_data     = r_wdata;
  assign bus.fwd_valid      = r_we;
  assign bus.fwd_rd         = r_wreg;
  assign bus.fwd_data       = r_wdata;
  assign bus.load_timeout   = r_timeout;

endmodule
